// File: rtl/hazard_ctrl.sv
// Pipeline hazard controller: load-use stall, taken-branch flush and data-memory
// wait freeze for a 5-stage MIPS pipeline, plus stall statistics and timeout flag.
module hazard_ctrl #(
   parameter int unsigned FLUSH_CYCLES = 2,
   parameter int unsigned MEM_TIMEOUT  = 16,
   parameter int unsigned CNT_W        = 16
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             IDEX_Mread,
   input  logic [4:0]       IDEX_rt,
   input  logic [4:0]       IFID_rs,
   input  logic [4:0]       IFID_rt,
   input  logic             IFID_uses_rt,
   input  logic             EX_branch_taken,
   input  logic             MEM_access,
   input  logic             dmem_ready,
   output logic             PC_write,
   output logic             IFID_write,
   output logic             IDEX_write,
   output logic             EXMEM_write,
   output logic             IFID_flush,
   output logic             IDEX_flush,
   output logic             mem_timeout_err,
   output logic [CNT_W-1:0] stall_cnt
);

   typedef enum logic [1:0] {RUN, BR_FLUSH, MEM_WAIT} state_e;

   localparam logic [2:0] FLUSH_INIT = 3'(FLUSH_CYCLES - 1);
   localparam logic [7:0] TIMEOUT    = 8'(MEM_TIMEOUT);

   state_e           state_q, state_d, eff_state;
   logic [2:0]       flush_q, flush_d;
   logic [7:0]       wait_q, wait_d;
   logic             err_q, err_d;
   logic [CNT_W-1:0] stall_q, stall_d;
   logic             lu, mw;

   always_comb begin
      lu = IDEX_Mread && (IDEX_rt != 5'd0) &&
           ((IDEX_rt == IFID_rs) || (IFID_uses_rt && (IDEX_rt == IFID_rt)));
      mw = MEM_access && !dmem_ready;
   end

   always_comb begin
      PC_write    = 1'b1;
      IFID_write  = 1'b1;
      IDEX_write  = 1'b1;
      EXMEM_write = 1'b1;
      IFID_flush  = 1'b0;
      IDEX_flush  = 1'b0;
      state_d     = state_q;
      flush_d     = flush_q;
      wait_d      = '0;
      err_d       = err_q;
      // Leaving MEM_WAIT behaves as the state it resumes, so a pending flush
      // continues in the very cycle memory becomes ready.
      eff_state   = state_q;
      if (state_q == MEM_WAIT) begin
         eff_state = (flush_q != 3'd0) ? BR_FLUSH : RUN;
      end
      if (rst) begin
         PC_write    = 1'b0;
         IFID_write  = 1'b0;
         IDEX_write  = 1'b0;
         EXMEM_write = 1'b0;
         IFID_flush  = 1'b1;
         IDEX_flush  = 1'b1;
      end else if (mw) begin
         PC_write    = 1'b0;
         IFID_write  = 1'b0;
         IDEX_write  = 1'b0;
         EXMEM_write = 1'b0;
         state_d     = MEM_WAIT;
         wait_d      = (wait_q >= TIMEOUT) ? wait_q : wait_q + 8'd1;
         if (wait_d >= TIMEOUT) begin
            err_d = 1'b1;
         end
      end else if (eff_state == BR_FLUSH) begin
         IFID_flush = 1'b1;
         IDEX_flush = 1'b1;
         flush_d    = flush_q - 3'd1;
         state_d    = (flush_q == 3'd1) ? RUN : BR_FLUSH;
      end else if (EX_branch_taken) begin
         IFID_flush = 1'b1;
         IDEX_flush = 1'b1;
         flush_d    = FLUSH_INIT;
         state_d    = (FLUSH_INIT == 3'd0) ? RUN : BR_FLUSH;
      end else if (lu) begin
         PC_write   = 1'b0;
         IFID_write = 1'b0;
         IDEX_flush = 1'b1;
         state_d    = RUN;
      end else begin
         state_d = RUN;
      end
   end

   always_comb begin
      stall_d = stall_q;
      if (!rst && !PC_write && (stall_q != '1)) begin
         stall_d = stall_q + CNT_W'(1);
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= RUN;
         flush_q <= '0;
         wait_q  <= '0;
         err_q   <= 1'b0;
         stall_q <= '0;
      end else begin
         state_q <= state_d;
         flush_q <= flush_d;
         wait_q  <= wait_d;
         err_q   <= err_d;
         stall_q <= stall_d;
      end
   end

   assign mem_timeout_err = err_q;
   assign stall_cnt       = stall_q;

endmodule

// File: tb/tb_hazard_ctrl.sv
// Scenario bench for hazard_ctrl: per-cycle stimulus with expected controls,
// stall count and error flag queued as driven and compared when sampled.
module tb_hazard_ctrl;

   typedef struct packed {
      logic       r;
      logic       mread;
      logic [4:0] irt;
      logic [4:0] rs;
      logic [4:0] rt;
      logic       urt;
      logic       bt;
      logic       macc;
      logic       rdy;
      logic [5:0] ctl;
      logic [3:0] cnt;
      logic       err;
   } vec_t;

   typedef struct packed {
      logic [5:0] ctl;
      logic [3:0] cnt;
      logic       err;
   } exp_t;

   // {PC_write, IFID_write, IDEX_write, EXMEM_write, IFID_flush, IDEX_flush}
   localparam logic [5:0] E_RUN = 6'b111100;
   localparam logic [5:0] E_LU  = 6'b001101;
   localparam logic [5:0] E_FRZ = 6'b000000;
   localparam logic [5:0] E_FL  = 6'b111111;
   localparam logic [5:0] E_RST = 6'b000011;

   logic       clk = 1'b0;
   logic       rst;
   logic       IDEX_Mread, IFID_uses_rt, EX_branch_taken, MEM_access, dmem_ready;
   logic [4:0] IDEX_rt, IFID_rs, IFID_rt;
   logic       PC_write, IFID_write, IDEX_write, EXMEM_write, IFID_flush, IDEX_flush;
   logic       mem_timeout_err;
   logic [3:0] stall_cnt;
   logic [5:0] ctl;

   exp_t exp_q[$];
   int   checks = 0;
   int   errors = 0;

   always #5 clk = ~clk;

   assign ctl = {PC_write, IFID_write, IDEX_write, EXMEM_write, IFID_flush, IDEX_flush};

   hazard_ctrl #(.FLUSH_CYCLES(2), .MEM_TIMEOUT(16), .CNT_W(4)) dut (
      .clk(clk), .rst(rst),
      .IDEX_Mread(IDEX_Mread), .IDEX_rt(IDEX_rt), .IFID_rs(IFID_rs), .IFID_rt(IFID_rt),
      .IFID_uses_rt(IFID_uses_rt), .EX_branch_taken(EX_branch_taken),
      .MEM_access(MEM_access), .dmem_ready(dmem_ready),
      .PC_write(PC_write), .IFID_write(IFID_write), .IDEX_write(IDEX_write),
      .EXMEM_write(EXMEM_write), .IFID_flush(IFID_flush), .IDEX_flush(IDEX_flush),
      .mem_timeout_err(mem_timeout_err), .stall_cnt(stall_cnt)
   );

   function automatic vec_t v(input logic r, input logic mread, input logic [4:0] irt,
                              input logic [4:0] rs, input logic [4:0] rt, input logic urt,
                              input logic bt, input logic macc, input logic rdy,
                              input logic [5:0] c, input logic [3:0] n, input logic e);
      vec_t x;
      x = '{r, mread, irt, rs, rt, urt, bt, macc, rdy, c, n, e};
      return x;
   endfunction

   task automatic apply(input vec_t x);
      rst = x.r; IDEX_Mread = x.mread; IDEX_rt = x.irt; IFID_rs = x.rs; IFID_rt = x.rt;
      IFID_uses_rt = x.urt; EX_branch_taken = x.bt; MEM_access = x.macc; dmem_ready = x.rdy;
      exp_q.push_back('{x.ctl, x.cnt, x.err});
   endtask

   task automatic reset_dut();
      apply(v(1, 0, 0, 0, 0, 0, 0, 0, 1, E_RST, 0, 0));
      void'(exp_q.pop_front());
      @(posedge clk); #1;
      rst = 1'b0;
   endtask

   task automatic test_reset();
      vec_t vq[$];
      exp_t e;
      vq.push_back(v(1, 0, 0, 0, 0, 0, 1, 1, 0, E_RST, 0, 0));
      vq.push_back(v(1, 0, 0, 0, 0, 0, 1, 1, 0, E_RST, 0, 0));
      vq.push_back(v(0, 0, 0, 0, 0, 0, 0, 0, 1, E_RUN, 0, 0));
      vq.push_back(v(0, 0, 0, 0, 0, 0, 0, 0, 1, E_RUN, 0, 0));
      foreach (vq[i]) begin
         apply(vq[i]);
         @(negedge clk);
         e = exp_q.pop_front();
         checks++; if (ctl !== e.ctl) begin errors++; $display("FAIL reset_ctl[%0d] got %b exp %b", i, ctl, e.ctl); end
         checks++; if (stall_cnt !== e.cnt) begin errors++; $display("FAIL reset_cnt[%0d] got %0d exp %0d", i, stall_cnt, e.cnt); end
         checks++; if (mem_timeout_err !== e.err) begin errors++; $display("FAIL reset_err[%0d] got %b exp %b", i, mem_timeout_err, e.err); end
         @(posedge clk); #1;
      end
   endtask

   task automatic test_load_use();
      vec_t vq[$];
      exp_t e;
      reset_dut();
      vq.push_back(v(0, 1, 8, 8, 0, 0, 0, 0, 1, E_LU,  0, 0));
      vq.push_back(v(0, 0, 0, 8, 0, 0, 0, 0, 1, E_RUN, 1, 0));
      vq.push_back(v(0, 1, 0, 0, 0, 0, 0, 0, 1, E_RUN, 1, 0));
      vq.push_back(v(0, 1, 8, 3, 8, 0, 0, 0, 1, E_RUN, 1, 0));
      vq.push_back(v(0, 1, 8, 3, 8, 1, 0, 0, 1, E_LU,  1, 0));
      vq.push_back(v(0, 0, 0, 0, 0, 0, 0, 0, 1, E_RUN, 2, 0));
      foreach (vq[i]) begin
         apply(vq[i]);
         @(negedge clk);
         e = exp_q.pop_front();
         checks++; if (ctl !== e.ctl) begin errors++; $display("FAIL lu_ctl[%0d] got %b exp %b", i, ctl, e.ctl); end
         checks++; if (stall_cnt !== e.cnt) begin errors++; $display("FAIL lu_cnt[%0d] got %0d exp %0d", i, stall_cnt, e.cnt); end
         checks++; if (mem_timeout_err !== e.err) begin errors++; $display("FAIL lu_err[%0d] got %b exp %b", i, mem_timeout_err, e.err); end
         @(posedge clk); #1;
      end
   endtask

   task automatic test_branch();
      vec_t vq[$];
      exp_t e;
      reset_dut();
      vq.push_back(v(0, 0, 0, 0, 0, 0, 1, 0, 1, E_FL,  0, 0));
      vq.push_back(v(0, 1, 8, 8, 0, 0, 0, 0, 1, E_FL,  0, 0));
      vq.push_back(v(0, 0, 0, 0, 0, 0, 0, 0, 1, E_RUN, 0, 0));
      vq.push_back(v(0, 1, 8, 8, 0, 0, 1, 0, 1, E_FL,  0, 0));
      vq.push_back(v(0, 0, 0, 0, 0, 0, 0, 0, 1, E_FL,  0, 0));
      vq.push_back(v(0, 0, 0, 0, 0, 0, 0, 0, 1, E_RUN, 0, 0));
      foreach (vq[i]) begin
         apply(vq[i]);
         @(negedge clk);
         e = exp_q.pop_front();
         checks++; if (ctl !== e.ctl) begin errors++; $display("FAIL br_ctl[%0d] got %b exp %b", i, ctl, e.ctl); end
         checks++; if (stall_cnt !== e.cnt) begin errors++; $display("FAIL br_cnt[%0d] got %0d exp %0d", i, stall_cnt, e.cnt); end
         @(posedge clk); #1;
      end
   endtask

   task automatic test_mem_wait();
      vec_t vq[$];
      exp_t e;
      reset_dut();
      for (int k = 0; k < 5; k++) vq.push_back(v(0, 0, 0, 0, 0, 0, 0, 1, 0, E_FRZ, 4'(k), 0));
      vq.push_back(v(0, 0, 0, 0, 0, 0, 0, 1, 1, E_RUN, 5, 0));
      vq.push_back(v(0, 0, 0, 0, 0, 0, 0, 0, 1, E_RUN, 5, 0));
      foreach (vq[i]) begin
         apply(vq[i]);
         @(negedge clk);
         e = exp_q.pop_front();
         checks++; if (ctl !== e.ctl) begin errors++; $display("FAIL mw_ctl[%0d] got %b exp %b", i, ctl, e.ctl); end
         checks++; if (stall_cnt !== e.cnt) begin errors++; $display("FAIL mw_cnt[%0d] got %0d exp %0d", i, stall_cnt, e.cnt); end
         checks++; if (mem_timeout_err !== e.err) begin errors++; $display("FAIL mw_err[%0d] got %b exp %b", i, mem_timeout_err, e.err); end
         @(posedge clk); #1;
      end
   endtask

   task automatic test_timeout_saturation();
      vec_t vq[$];
      exp_t e;
      reset_dut();
      for (int k = 0; k < 20; k++)
         vq.push_back(v(0, 0, 0, 0, 0, 0, 0, 1, 0, E_FRZ, (k > 15) ? 4'd15 : 4'(k), (k >= 16) ? 1'b1 : 1'b0));
      vq.push_back(v(0, 0, 0, 0, 0, 0, 0, 1, 1, E_RUN, 15, 1));
      vq.push_back(v(0, 0, 0, 0, 0, 0, 0, 0, 1, E_RUN, 15, 1));
      vq.push_back(v(1, 0, 0, 0, 0, 0, 0, 0, 1, E_RST, 15, 1));
      vq.push_back(v(0, 0, 0, 0, 0, 0, 0, 0, 1, E_RUN, 0,  0));
      foreach (vq[i]) begin
         apply(vq[i]);
         @(negedge clk);
         e = exp_q.pop_front();
         checks++; if (ctl !== e.ctl) begin errors++; $display("FAIL to_ctl[%0d] got %b exp %b", i, ctl, e.ctl); end
         checks++; if (stall_cnt !== e.cnt) begin errors++; $display("FAIL to_cnt[%0d] got %0d exp %0d", i, stall_cnt, e.cnt); end
         checks++; if (mem_timeout_err !== e.err) begin errors++; $display("FAIL to_err[%0d] got %b exp %b", i, mem_timeout_err, e.err); end
         @(posedge clk); #1;
      end
   endtask

   task automatic test_simultaneous();
      vec_t vq[$];
      exp_t e;
      reset_dut();
      vq.push_back(v(0, 0, 0, 0, 0, 0, 1, 0, 1, E_FL,  0, 0));
      vq.push_back(v(0, 0, 0, 0, 0, 0, 0, 1, 0, E_FRZ, 0, 0));
      vq.push_back(v(0, 0, 0, 0, 0, 0, 0, 1, 0, E_FRZ, 1, 0));
      vq.push_back(v(0, 0, 0, 0, 0, 0, 0, 1, 0, E_FRZ, 2, 0));
      vq.push_back(v(0, 0, 0, 0, 0, 0, 0, 1, 1, E_FL,  3, 0));
      vq.push_back(v(0, 0, 0, 0, 0, 0, 0, 0, 1, E_RUN, 3, 0));
      vq.push_back(v(0, 0, 0, 0, 0, 0, 1, 1, 0, E_FRZ, 3, 0));
      vq.push_back(v(0, 0, 0, 0, 0, 0, 1, 1, 1, E_FL,  4, 0));
      vq.push_back(v(0, 0, 0, 0, 0, 0, 0, 0, 1, E_FL,  4, 0));
      vq.push_back(v(0, 0, 0, 0, 0, 0, 0, 0, 1, E_RUN, 4, 0));
      foreach (vq[i]) begin
         apply(vq[i]);
         @(negedge clk);
         e = exp_q.pop_front();
         checks++; if (ctl !== e.ctl) begin errors++; $display("FAIL sim_ctl[%0d] got %b exp %b", i, ctl, e.ctl); end
         checks++; if (stall_cnt !== e.cnt) begin errors++; $display("FAIL sim_cnt[%0d] got %0d exp %0d", i, stall_cnt, e.cnt); end
         @(posedge clk); #1;
      end
   endtask

   task automatic test_reset_mid();
      vec_t vq[$];
      exp_t e;
      reset_dut();
      vq.push_back(v(0, 0, 0, 0, 0, 0, 0, 1, 0, E_FRZ, 0, 0));
      vq.push_back(v(0, 0, 0, 0, 0, 0, 0, 1, 0, E_FRZ, 1, 0));
      vq.push_back(v(1, 1, 8, 8, 0, 0, 1, 1, 0, E_RST, 2, 0));
      vq.push_back(v(0, 0, 0, 0, 0, 0, 0, 0, 1, E_RUN, 0, 0));
      vq.push_back(v(0, 0, 0, 0, 0, 0, 1, 0, 1, E_FL,  0, 0));
      vq.push_back(v(1, 0, 0, 0, 0, 0, 0, 0, 1, E_RST, 0, 0));
      vq.push_back(v(0, 0, 0, 0, 0, 0, 0, 0, 1, E_RUN, 0, 0));
      foreach (vq[i]) begin
         apply(vq[i]);
         @(negedge clk);
         e = exp_q.pop_front();
         checks++; if (ctl !== e.ctl) begin errors++; $display("FAIL rmid_ctl[%0d] got %b exp %b", i, ctl, e.ctl); end
         checks++; if (stall_cnt !== e.cnt) begin errors++; $display("FAIL rmid_cnt[%0d] got %0d exp %0d", i, stall_cnt, e.cnt); end
         @(posedge clk); #1;
      end
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog simulation did not finish");
      $fatal(1);
   end

   initial begin
      rst = 1'b1; IDEX_Mread = 1'b0; IDEX_rt = '0; IFID_rs = '0; IFID_rt = '0;
      IFID_uses_rt = 1'b0; EX_branch_taken = 1'b0; MEM_access = 1'b0; dmem_ready = 1'b1;
      @(posedge clk); #1;
      test_reset();
      test_load_use();
      test_branch();
      test_mem_wait();
      test_timeout_saturation();
      test_simultaneous();
      test_reset_mid();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/hazard_ctrl.md
Name: hazard_ctrl

Overview:
- Pipeline control unit that produces the write-enable (stall) and flush (bubble) controls consumed by the PC, IF/ID, ID/EX and EX/MEM pipeline registers.
- Detects three conditions:
  - load-use data hazards, between the instruction in ID/EX and the instruction in IF/ID;
  - taken branches resolved in EX;
  - data-memory wait states in MEM.
- Sits beside the ID stage in the 5-stage MIPS pipeline. Its IDEX_flush output drives the ID/EX register's rst; IDEX_write drives that register's Write.

Parameters:
- FLUSH_CYCLES, 2: number of consecutive cycles IF/ID and ID/EX are flushed after a taken branch (1..7).
- MEM_TIMEOUT, 16: maximum number of MEM wait cycles before the sticky error flag sets (2..255).
- CNT_W, 16: width of the stall statistics counter.

Ports:
- clk  in  1  system clock; all state updates on posedge.
- rst  in  1  synchronous, active-high reset.
- IDEX_Mread  in  1  instruction in ID/EX is a load.
- IDEX_rt  in  5  destination register of the ID/EX load.
- IFID_rs  in  5  rs field of the instruction in IF/ID.
- IFID_rt  in  5  rt field of the instruction in IF/ID.
- IFID_uses_rt  in  1  IF/ID instruction reads rt as a source.
- EX_branch_taken  in  1  branch in EX resolved as taken this cycle.
- MEM_access  in  1  instruction in MEM performs a load or store.
- dmem_ready  in  1  data memory has completed the current access.
- PC_write  out  1  PC update enable.
- IFID_write  out  1  IF/ID register load enable.
- IDEX_write  out  1  ID/EX register load enable.
- EXMEM_write  out  1  EX/MEM register load enable.
- IFID_flush  out  1  clear IF/ID (insert a NOP).
- IDEX_flush  out  1  clear ID/EX (insert a bubble).
- mem_timeout_err  out  1  sticky flag: MEM wait exceeded MEM_TIMEOUT.
- stall_cnt  out  CNT_W  saturating count of stall cycles since reset.

Behaviour:
- States: RUN, BR_FLUSH, MEM_WAIT. The state register and counters update on posedge clk.
- Outputs are combinational from the current state and the inputs.
- Reset:
  - while rst=1 (evaluated at each posedge): state becomes RUN; flush counter, wait counter and stall_cnt become 0; mem_timeout_err becomes 0.
  - while rst=1 the combinational outputs are: all four *_write=0, IFID_flush=1, IDEX_flush=1.
  - reset mid-operation (in any state) behaves identically. No hazard is remembered across reset.
- Default outputs, in RUN with no hazard: all *_write=1, both flushes=0.
- Load-use hazard (lu): IDEX_Mread=1 AND IDEX_rt!=0 AND (IDEX_rt==IFID_rs OR (IFID_uses_rt=1 AND IDEX_rt==IFID_rt)).
  - Response in the same cycle: PC_write=0, IFID_write=0, IDEX_flush=1.
  - IDEX_write and EXMEM_write stay 1.
  - Exactly one bubble per load. The next cycle the load has left ID/EX, so lu deasserts naturally.
- Memory wait (mw): MEM_access=1 AND dmem_ready=0.
  - Freeze: all four *_write=0, both flushes=0.
  - Next state is MEM_WAIT.
  - In MEM_WAIT, the wait counter increments each cycle while mw holds.
  - When the wait counter reaches MEM_TIMEOUT, mem_timeout_err sets. It is sticky until rst. The freeze continues.
  - When dmem_ready=1: return to RUN and clear the wait counter.
- Branch taken (bt) in RUN:
  - Same cycle: IFID_flush=1 and IDEX_flush=1; PC_write=1 so the target loads.
  - Next state is BR_FLUSH with the flush counter set to FLUSH_CYCLES-1.
  - In BR_FLUSH, both flushes=1 and all writes=1; the counter decrements each cycle. At 0 the state returns to RUN.
  - If FLUSH_CYCLES=1, there is no BR_FLUSH visit.
- Priority for simultaneous events: mw > bt > lu.
  - mw during BR_FLUSH: freeze takes effect and the flush counter holds. The remaining flushes resume after the wait.
  - bt arriving while lu is true: flush only; the load-use stall is dropped because its consumer is squashed.
  - lu is ignored in BR_FLUSH, since IF/ID is being flushed.
- stall_cnt increments by 1 in every cycle where PC_write=0 and rst=0. It saturates at 2^CNT_W-1 with no wrap.

Test Plan:
- Reset: hold rst=1 for 2 cycles with bt=1 and mw=1 → all writes 0, both flushes 1; after release state is RUN, writes 1, flushes 0, stall_cnt=0, mem_timeout_err=0.
- Load-use: IDEX_Mread=1, IDEX_rt=8, IFID_rs=8 → exactly 1 cycle with PC_write=0, IFID_write=0, IDEX_flush=1, and stall_cnt=1 afterwards. The same stimulus with IDEX_rt=0, or with IFID_rt=8 and IFID_uses_rt=0, gives no stall.
- Branch flush: EX_branch_taken=1 for one cycle with FLUSH_CYCLES=2 → IFID_flush and IDEX_flush high for exactly 2 cycles with PC_write=1 throughout.
- Memory wait: MEM_access=1, dmem_ready=0 for 5 cycles, then 1 → all writes 0 for exactly 5 cycles, stall_cnt=5, no error. Holding dmem_ready=0 for 20 cycles with MEM_TIMEOUT=16 → mem_timeout_err rises after the 16th wait cycle and stays high until rst.
- Simultaneous events:
  - bt together with lu → flush only, PC_write=1.
  - mw asserted during the 2nd BR_FLUSH cycle for 3 cycles → 3 frozen cycles, then 1 remaining flush cycle, then RUN.
- Saturation: with CNT_W=4, force 20 stall cycles → stall_cnt stays at 15.
